// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, reset values,
// register selection and byte-strobe merge helpers.
package clint_pkg;

   localparam logic [15:0] CLINT_MSIP     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
   localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;
   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_TIME_LO,
      REG_TIME_HI
   } clint_reg_e;

   localparam logic [15:0] CLINT_MTIMECMP_HI = CLINT_MTIMECMP + 16'h0004;
   localparam logic [15:0] CLINT_MTIME_HI    = CLINT_MTIME + 16'h0004;

   // Decodes the word index (byte offset bits [15:2]) into a register selection.
   function automatic clint_reg_e clint_decode(input logic [13:0] word);
      clint_reg_e sel;
      case (word)
         CLINT_MSIP[15:2]:        sel = REG_MSIP;
         CLINT_MTIMECMP[15:2]:    sel = REG_CMP_LO;
         CLINT_MTIMECMP_HI[15:2]: sel = REG_CMP_HI;
         CLINT_MTIME[15:2]:       sel = REG_TIME_LO;
         CLINT_MTIME_HI[15:2]:    sel = REG_TIME_HI;
         default:                 sel = REG_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/riscv_clint.sv
// Machine-level CLINT for a single RV32 hart: mtime/mtimecmp/msip behind a one-cycle
// valid/ready bus, driving msip, mtip and mtime directly into the core.
module riscv_clint
   import clint_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clint_valid,
   input  logic        clint_instr,
   input  logic [31:0] clint_addr,
   input  logic [31:0] clint_wdata,
   input  logic [3:0]  clint_wstrb,
   output logic [31:0] clint_rdata,
   output logic        clint_ready,
   output logic        clint_msip,
   output logic        clint_mtip,
   output logic [63:0] clint_mtime
);

   localparam int unsigned   PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICK_DIV - 1);

   clint_reg_e    sel;
   logic          wr;
   logic          tick;
   logic [PW-1:0] prescale;
   logic [63:0]   mtime;
   logic [63:0]   mtimecmp;
   logic          msip;
   logic [31:0]   rd_val;

   // The fetch flag and undecoded address bits carry no meaning for this block.
   logic unused_ok;
   assign unused_ok = ^{clint_instr, clint_addr[31:16], clint_addr[1:0]};

   assign sel  = clint_decode(clint_addr[15:2]);
   assign wr   = clint_valid && (clint_wstrb != 4'b0000);
   assign tick = (prescale == PRESCALE_MAX);

   // NOTE: state registers use non-blocking assignments so every block samples
   // the pre-edge values, which is what makes reads return pre-write data.
   always_ff @(posedge clock) begin
      if (reset) begin
         prescale <= '0;
      end else if (tick) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + PW'(1);
      end
   end

   // A write to either half loads only that half and skips the increment.
   always_ff @(posedge clock) begin
      if (reset) begin
         mtime <= '0;
      end else if (wr && sel == REG_TIME_LO) begin
         mtime[31:0] <= strb_merge(mtime[31:0], clint_wdata, clint_wstrb);
      end else if (wr && sel == REG_TIME_HI) begin
         mtime[63:32] <= strb_merge(mtime[63:32], clint_wdata, clint_wstrb);
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mtimecmp <= MTIMECMP_RESET;
         msip     <= 1'b0;
      end else if (wr) begin
         case (sel)
            REG_CMP_LO: mtimecmp[31:0]  <= strb_merge(mtimecmp[31:0], clint_wdata, clint_wstrb);
            REG_CMP_HI: mtimecmp[63:32] <= strb_merge(mtimecmp[63:32], clint_wdata, clint_wstrb);
            REG_MSIP:   if (clint_wstrb[0]) msip <= clint_wdata[0];
            default:    ;
         endcase
      end
   end

   // NOTE: rd_val gets a default before the case so no path leaves it unassigned
   // (which would otherwise infer a latch).
   always_comb begin
      rd_val = '0;
      case (sel)
         REG_MSIP:    rd_val = {31'd0, msip};
         REG_CMP_LO:  rd_val = mtimecmp[31:0];
         REG_CMP_HI:  rd_val = mtimecmp[63:32];
         REG_TIME_LO: rd_val = mtime[31:0];
         REG_TIME_HI: rd_val = mtime[63:32];
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         clint_ready <= 1'b0;
         clint_rdata <= '0;
      end else begin
         clint_ready <= clint_valid;
         clint_rdata <= clint_valid ? rd_val : 32'd0;
      end
   end

   assign clint_msip  = msip;
   assign clint_mtip  = (mtime >= mtimecmp);
   assign clint_mtime = mtime;

endmodule

// File: tb/tb_riscv_clint.sv
// Directed bench for riscv_clint: a register-access vector table plus hand-written
// sequences for timer compare, carry, wrap and reset-during-request.
module tb_riscv_clint;

   logic        clock;
   logic        reset;
   logic        clint_valid;
   logic        clint_instr;
   logic [31:0] clint_addr;
   logic [31:0] clint_wdata;
   logic [3:0]  clint_wstrb;
   logic [31:0] clint_rdata;
   logic        clint_ready;
   logic        clint_msip;
   logic        clint_mtip;
   logic [63:0] clint_mtime;

   int checks   = 0;
   int failures = 0;

   riscv_clint #(.TICK_DIV(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .clint_valid (clint_valid),
      .clint_instr (clint_instr),
      .clint_addr  (clint_addr),
      .clint_wdata (clint_wdata),
      .clint_wstrb (clint_wstrb),
      .clint_rdata (clint_rdata),
      .clint_ready (clint_ready),
      .clint_msip  (clint_msip),
      .clint_mtip  (clint_mtip),
      .clint_mtime (clint_mtime)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        chk_rd;
      logic [31:0] exp_rdata;
      logic        exp_msip;
   } vec_t;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Called at a falling edge; issues one request and returns at the next falling
   // edge, where the response is sampled.
   task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic chk_rd,
                         input logic [31:0] exp_rdata);
      clint_valid = 1'b1;
      clint_addr  = addr;
      clint_wdata = wdata;
      clint_wstrb = wstrb;
      @(negedge clock);
      check("ready", {63'd0, clint_ready}, 64'd1);
      if (chk_rd) check("rdata", {32'd0, clint_rdata}, {32'd0, exp_rdata});
      clint_valid = 1'b0;
      clint_wstrb = 4'b0000;
   endtask

   task automatic check_idle();
      @(negedge clock);
      check("idle_ready", {63'd0, clint_ready}, 64'd0);
      check("idle_rdata", {32'd0, clint_rdata}, 64'd0);
   endtask

   vec_t vecs[18];
   logic [63:0] exp_t;

   initial begin
      vecs[0]  = '{32'h0000_0000, 32'h0000_0001, 4'b1111, 1'b0, 32'h0,           1'b1};
      vecs[1]  = '{32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0001,   1'b1};
      vecs[2]  = '{32'h0000_0000, 32'hFFFF_FFFE, 4'b1111, 1'b0, 32'h0,           1'b0};
      vecs[3]  = '{32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'h0,           1'b0};
      vecs[4]  = '{32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0,           1'b1};
      vecs[5]  = '{32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'h0000_0001,   1'b1};
      vecs[6]  = '{32'h0000_0000, 32'h0,         4'b1111, 1'b0, 32'h0,           1'b0};
      vecs[7]  = '{32'h0000_4000, 32'hAABB_CCDD, 4'b0010, 1'b0, 32'h0,           1'b0};
      vecs[8]  = '{32'h0000_4000, 32'h0,         4'b0000, 1'b1, 32'hFFFF_CCFF,   1'b0};
      vecs[9]  = '{32'h0000_4004, 32'h1234_5678, 4'b1001, 1'b0, 32'h0,           1'b0};
      vecs[10] = '{32'h0000_4004, 32'h0,         4'b0000, 1'b1, 32'h12FF_FF78,   1'b0};
      vecs[11] = '{32'h0000_4006, 32'h0,         4'b0000, 1'b1, 32'h12FF_FF78,   1'b0};
      vecs[12] = '{32'h0000_1234, 32'h0,         4'b0000, 1'b1, 32'h0,           1'b0};
      vecs[13] = '{32'h0000_1234, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,           1'b0};
      vecs[14] = '{32'h0000_4000, 32'h0,         4'b0000, 1'b1, 32'hFFFF_CCFF,   1'b0};
      vecs[15] = '{32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'h0,           1'b0};
      vecs[16] = '{32'h0000_0000, 32'h0000_0001, 4'b0000, 1'b1, 32'h0,           1'b0};
      vecs[17] = '{32'h0000_0000, 32'h0000_0001, 4'b1110, 1'b0, 32'h0,           1'b0};

      reset       = 1'b1;
      clint_valid = 1'b0;
      clint_instr = 1'b0;
      clint_addr  = '0;
      clint_wdata = '0;
      clint_wstrb = '0;

      // Reset state and free-running count.
      @(negedge clock);
      check("rst_ready", {63'd0, clint_ready}, 64'd0);
      check("rst_rdata", {32'd0, clint_rdata}, 64'd0);
      check("rst_msip",  {63'd0, clint_msip},  64'd0);
      check("rst_mtip",  {63'd0, clint_mtip},  64'd0);
      check("rst_mtime", clint_mtime, 64'd0);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      check("mtime_5", clint_mtime, 64'd5);

      // Register access table, back-to-back requests.
      for (int i = 0; i < 18; i++) begin
         do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].chk_rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_msip", i), {63'd0, clint_msip}, {63'd0, vecs[i].exp_msip});
         check($sformatf("vec%0d_mtip", i), {63'd0, clint_mtip}, 64'd0);
      end
      check_idle();

      // Timer compare around mtimecmp = 0x40.
      do_req(32'hBFFC, 32'h0, 4'b1111, 1'b0, 32'h0);
      do_req(32'hBFF8, 32'h0, 4'b1111, 1'b0, 32'h0);
      check("mtime_load0", clint_mtime, 64'd0);
      do_req(32'h4004, 32'h0,  4'b1111, 1'b0, 32'h0);
      do_req(32'h4000, 32'h40, 4'b1111, 1'b0, 32'h0);
      exp_t = 64'd2;
      check("mtime_2", clint_mtime, exp_t);
      check("mtip_early", {63'd0, clint_mtip}, 64'd0);
      while (exp_t < 64'h43) begin
         @(negedge clock);
         exp_t++;
         if (exp_t >= 64'h3E)
            check($sformatf("mtip_at_%0h", exp_t), {63'd0, clint_mtip}, {63'd0, exp_t >= 64'h40});
         if (exp_t == 64'h40) check("mtime_40", clint_mtime, 64'h40);
      end
      do_req(32'h4000, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0);
      check("mtip_drop", {63'd0, clint_mtip}, 64'd0);

      // Carry from lo into hi after a split write.
      do_req(32'hBFF8, 32'hFFFF_FFFE, 4'b1111, 1'b0, 32'h0);
      do_req(32'hBFFC, 32'h0,         4'b1111, 1'b0, 32'h0);
      check("mtime_suppr", clint_mtime, 64'h0000_0000_FFFF_FFFE);
      @(negedge clock);
      check("mtime_ff", clint_mtime, 64'h0000_0000_FFFF_FFFF);
      @(negedge clock);
      check("mtime_carry", clint_mtime, 64'h0000_0001_0000_0000);
      do_req(32'hBFFC, 32'h0, 4'b0000, 1'b1, 32'h0000_0001);

      // mtime wrap against all-ones mtimecmp.
      do_req(32'h4004, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0);
      do_req(32'hBFFC, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0);
      do_req(32'hBFF8, 32'hFFFF_FFFD, 4'b1111, 1'b0, 32'h0);
      check("wrap_fd",      clint_mtime, 64'hFFFF_FFFF_FFFF_FFFD);
      check("wrap_fd_mtip", {63'd0, clint_mtip}, 64'd0);
      @(negedge clock);
      check("wrap_fe_mtip", {63'd0, clint_mtip}, 64'd0);
      @(negedge clock);
      check("wrap_ff",      clint_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
      check("wrap_ff_mtip", {63'd0, clint_mtip}, 64'd1);
      @(negedge clock);
      check("wrap_0",       clint_mtime, 64'd0);
      check("wrap_0_mtip",  {63'd0, clint_mtip}, 64'd0);

      // Reset during a request drops the response and restores register defaults.
      do_req(32'h0000, 32'h1, 4'b1111, 1'b0, 32'h0);
      check("pre_rst_msip", {63'd0, clint_msip}, 64'd1);
      reset       = 1'b1;
      clint_valid = 1'b1;
      clint_addr  = 32'h0000;
      clint_wstrb = 4'b0000;
      @(negedge clock);
      check("midrst_ready", {63'd0, clint_ready}, 64'd0);
      check("midrst_rdata", {32'd0, clint_rdata}, 64'd0);
      check("midrst_msip",  {63'd0, clint_msip},  64'd0);
      check("midrst_mtime", clint_mtime, 64'd0);
      reset       = 1'b0;
      clint_valid = 1'b0;
      do_req(32'hBFF8, 32'h0, 4'b0000, 1'b1, 32'h0);
      do_req(32'h4000, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FFFF);
      do_req(32'h4004, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FFFF);
      check_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
